// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: serializer state encoding and default timing.
// The receive side is expected to import the same defaults.
package uart_tx_fifo_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DEFAULT_FIFO_DEPTH   = 8;
    localparam int DEFAULT_FIFO_AW      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Line level driven while the serializer sits in a given state.
    function automatic logic tx_level(input tx_state_e st, input logic data_bit);
        case (st)
            ST_START: tx_level = 1'b0;
            ST_DATA:  tx_level = data_bit;
            default:  tx_level = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and a registered full flag.
// Writes are not guarded here; the parent never writes while full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_full;

    always_comb begin
        w_count_nxt = r_count;
        if (i_wr_en && !i_rd_en) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!i_wr_en && i_rd_en) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = r_full;
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: CPU-side byte strobe into a FIFO, serialized on o_tx.
//
// state    | meaning
// ST_IDLE  | line high, waiting for a queued byte
// ST_START | start bit (low) for one bit period
// ST_DATA  | eight data bits, LSB first
// ST_STOP  | stop bit (high); chains straight into the next start bit if data is queued
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int FIFO_AW      = DEFAULT_FIFO_AW
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_byte,
    input  logic       i_transmit,
    output logic       o_is_transmitting,
    output logic       o_tx_idle,
    output logic       o_overflow,
    output logic       o_tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         r_state;
    tx_state_e         w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_overflow;

    logic              w_wr_en;
    logic              w_pop;
    logic              w_bit_end;
    logic [7:0]        w_rd_data;
    logic [FIFO_AW:0]  w_count;
    logic              w_full;
    logic              w_empty;

    // A strobe while full is dropped even if a pop frees a slot on the same edge.
    assign w_wr_en = i_transmit && !w_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (i_tx_byte),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_bit_end = (r_baud == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit_idx;
        w_pop       = 1'b0;

        if (r_state != ST_IDLE && !w_bit_end) begin
            w_baud_nxt = r_baud - 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_count != '0) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_rd_data;
                    w_baud_nxt  = BAUD_LAST;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_bit_nxt   = '0;
                    w_baud_nxt  = BAUD_LAST;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt  = BAUD_LAST;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (w_count != '0) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_rd_data;
                        w_baud_nxt  = BAUD_LAST;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes on the state edge.
        w_tx_nxt = tx_level(w_state_nxt, w_shift_nxt[0]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
            r_overflow <= r_overflow || (i_transmit && w_full);
        end
    end

    assign o_tx              = r_tx;
    assign o_overflow        = r_overflow;
    assign o_is_transmitting = w_full;
    assign o_tx_idle         = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed plus randomized bench: a line decoder rebuilds frames from tx and the
// main sequence compares them with the bytes it expects to be accepted.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FRAME = 10 * CPB;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       is_tx;
    logic       tx_idle;
    logic       overflow;
    logic       tx_line;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int full_cnt = 0;

    logic [7:0] rx_data [$];
    int         rx_start [$];
    logic       rx_ok [$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .FIFO_AW      (AW)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_tx_byte         (tx_byte),
        .i_transmit        (transmit),
        .o_is_transmitting (is_tx),
        .o_tx_idle         (tx_idle),
        .o_overflow        (overflow),
        .o_tx              (tx_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (is_tx === 1'b1) full_cnt <= full_cnt + 1;

    // Line decoder: a frame is a low start bit, 8 steady data bits, a high stop bit.
    initial begin
        logic [7:0] d;
        logic       ok;
        logic       ab;
        logic       b;
        int         st;
        d = '0;
        b = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && tx_line === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                ab = 1'b0;
                for (int i = 1; i < CPB; i++) begin
                    @(negedge clk);
                    ab = ab | rst;
                    if (tx_line !== 1'b0) ok = 1'b0;
                end
                for (int bi = 0; bi < 8; bi++) begin
                    for (int j = 0; j < CPB; j++) begin
                        @(negedge clk);
                        ab = ab | rst;
                        if (j == 0) b = tx_line;
                        else if (tx_line !== b) ok = 1'b0;
                    end
                    d[bi] = b;
                end
                for (int j = 0; j < CPB; j++) begin
                    @(negedge clk);
                    ab = ab | rst;
                    if (tx_line !== 1'b1) ok = 1'b0;
                end
                if (!ab) begin
                    rx_data.push_back(d);
                    rx_start.push_back(st);
                    rx_ok.push_back(ok);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b, output int at);
        tx_byte  = b;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        at = cyc;
    endtask

    task automatic wait_idle(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_idle === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Accepted bytes must come out in order as back-to-back frames from 'first'.
    task automatic check_frames(input byte_q_t exp, input int first);
        check("frame_count", 32'(rx_data.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rx_data.size(); i++) begin
            check($sformatf("frame%0d_data", i), 32'(rx_data[i]), 32'(exp[i]));
            check($sformatf("frame%0d_shape", i), 32'(rx_ok[i]), 32'd1);
            check($sformatf("frame%0d_start", i), rx_start[i], first + i * FRAME);
        end
        rx_data.delete();
        rx_start.delete();
        rx_ok.delete();
    endtask

    initial begin
        int      n;
        int      t;
        int      k;
        int      len;
        byte_q_t exp;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_line), 32'd1);
        check("rst_is_tx", 32'(is_tx), 32'd0);
        check("rst_tx_idle", 32'(tx_idle), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single byte
        strobe(8'h55, n);
        check("single_idle_drop", 32'(tx_idle), 32'd0);
        wait_idle(200, t);
        check("single_idle_rise", t, n + 1 + FRAME);
        exp = '{8'h55};
        check_frames(exp, n + 1);

        // burst of three
        k = full_cnt;
        strobe(8'h01, n);
        strobe(8'h80, t);
        strobe(8'hFF, t);
        wait_idle(400, t);
        check("burst_idle_rise", t, n + 1 + 3 * FRAME);
        check("burst_no_backpressure", full_cnt, k);
        check("burst_overflow", 32'(overflow), 32'd0);
        exp = '{8'h01, 8'h80, 8'hFF};
        check_frames(exp, n + 1);

        // fill until full, then one dropped strobe
        strobe(8'hA0, n);
        strobe(8'hA1, t);
        strobe(8'hA2, t);
        strobe(8'hA3, t);
        check("fill_not_yet_full", 32'(is_tx), 32'd0);
        strobe(8'hA4, t);
        check("fill_full", 32'(is_tx), 32'd1);
        check("fill_overflow_before", 32'(overflow), 32'd0);
        strobe(8'hA5, t);
        check("fill_overflow_set", 32'(overflow), 32'd1);
        wait_idle(600, t);
        check("fill_idle_rise", t, n + 1 + 5 * FRAME);
        check("fill_overflow_sticky", 32'(overflow), 32'd1);
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_frames(exp, n + 1);

        // push while full on the same edge as the stop-bit pop
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_clears_overflow", 32'(overflow), 32'd0);
        strobe(8'hB0, n);
        strobe(8'hB1, t);
        strobe(8'hB2, t);
        strobe(8'hB3, t);
        strobe(8'hB4, t);
        check("pp_full", 32'(is_tx), 32'd1);
        while (cyc < n + FRAME) @(negedge clk);
        strobe(8'h3C, t);
        check("pp_overflow", 32'(overflow), 32'd1);
        check("pp_count_dec", 32'(is_tx), 32'd0);
        wait_idle(600, t);
        check("pp_idle_rise", t, n + 1 + 5 * FRAME);
        exp = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        check_frames(exp, n + 1);

        // reset in the middle of data bit 3
        strobe(8'hC3, n);
        strobe(8'h11, t);
        strobe(8'h22, t);
        while (cyc < n + 18) @(negedge clk);
        check("mid_bit3_low", 32'(tx_line), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_high", 32'(tx_line), 32'd1);
        check("mid_rst_idle", 32'(tx_idle), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_no_frames", 32'(rx_data.size()), 32'd0);
        check("post_rst_tx_idle", 32'(tx_idle), 32'd1);
        check("post_rst_overflow", 32'(overflow), 32'd0);
        check("post_rst_tx", 32'(tx_line), 32'd1);
        rx_data.delete();
        rx_start.delete();
        rx_ok.delete();

        // pointer wrap: ten spaced single bytes
        for (int i = 0; i < 10; i++) begin
            strobe(8'(i), n);
            wait_idle(100, t);
            check($sformatf("wrap%0d_idle", i), t, n + 1 + FRAME);
            exp = '{8'(i)};
            check_frames(exp, n + 1);
        end

        // random bursts: from idle, up to DEPTH queued plus one in the serializer fit
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, DEPTH + 1));
            exp.delete();
            n = 0;
            for (int j = 0; j < len; j++) begin
                exp.push_back(8'($urandom));
                strobe(exp[j], t);
                if (j == 0) n = t;
            end
            wait_idle(len * FRAME + 50, t);
            check($sformatf("rand%0d_idle", r), t, n + 1 + len * FRAME);
            check($sformatf("rand%0d_overflow", r), 32'(overflow), 32'd0);
            check_frames(exp, n + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
